seven_seg_scan_mux: RTL

//  Time-multiplexed scanner for a common-anode multi-digit 7-seg display.

---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_seg_refresh_tick.sv | 38 +++
 rtl/seven_seg_scan_mux.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module : seven_seg_pkg
// Brief  : Shared types and constants for the 7-segment scan multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    typedef logic [3:0] hex_nibble_t;

    localparam logic       ANODE_OFF = 1'b1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : seven_seg_pkg

`default_nettype wire

// File: rtl/seven_seg_refresh_tick.sv
// ============================================================================
// Module : seven_seg_refresh_tick
// Brief  : Slot prescaler; flags the last cycle of a slot and the blank window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_refresh_tick #(
    parameter  int DIV   = 50000,
    parameter  int BLANK = 16,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick_o,
    output logic             in_blank_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick_o     = (count_q == CNT_W'(DIV - 1));
    assign count_d    = tick_o ? '0 : count_q + CNT_W'(1);
    assign in_blank_o = (int'(count_q) < BLANK);
    assign count_o    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : seven_seg_refresh_tick

`default_nettype wire

// File: rtl/seven_seg_scan_mux.sv
// ============================================================================
// Module : seven_seg_scan_mux
// Brief  : Double-buffered multi-digit scanner for a common-anode 7-seg display.
//          Optional leading-zero suppression via macro SEVEN_SEG_LZ_BLANK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output hex_nibble_t             hex_digit_o,
    output logic [IDX_W-1:0]        digit_idx_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic             w_tick;
    logic             w_in_blank;
    logic [CNT_W-1:0] w_count;
    logic             w_blank_next;
    logic             w_frame;
    logic             w_suppress;

    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [4*NUM_DIGITS-1:0] display_q,  display_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic                    pending_q,  pending_d;
    hex_nibble_t             hex_q,      hex_d;
    logic [NUM_DIGITS-1:0]   en_q,       en_d;

    seven_seg_refresh_tick #(
        .DIV   (REFRESH_DIV),
        .BLANK (BLANK_CYCLES)
    ) u_refresh_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_o     (w_tick),
        .in_blank_o (w_in_blank),
        .count_o    (w_count)
    );

    // Outputs are registered, so they are computed from the state the
    // prescaler and digit counter will hold after this edge.
    assign w_blank_next = w_tick ? (BLANK_CYCLES > 0)
                                 : (w_in_blank && (int'(w_count) + 1 < BLANK_CYCLES));
    assign w_frame      = w_tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [IDX_W-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (display_d[4*i +: 4] != 4'h0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    assign w_suppress = (idx_d > w_msd);
`else
    assign w_suppress = 1'b0;
`endif

    always_comb begin
        idx_d      = idx_q;
        display_d  = display_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;

        if (w_tick) begin
            idx_d = w_frame ? '0 : idx_q + IDX_W'(1);
        end

        // A load coinciding with the boundary bypasses the pending buffer.
        if (w_frame) begin
            if (load_i) begin
                display_d = value_i;
            end else if (pending_q) begin
                display_d = pend_val_q;
            end
            pending_d = 1'b0;
        end else if (load_i) begin
            pend_val_d = value_i;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        hex_d = '0;
        en_d  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx_d) == i) begin
                hex_d = display_d[4*i +: 4];
            end
            en_d[i] = (!w_blank_next && !w_suppress && (int'(idx_d) == i)) ? ~ANODE_OFF
                                                                          : ANODE_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            display_q  <= '0;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            hex_q      <= '0;
            en_q       <= {NUM_DIGITS{ANODE_OFF}};
        end else begin
            idx_q      <= idx_d;
            display_q  <= display_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            hex_q      <= hex_d;
            en_q       <= en_d;
        end
    end

    assign pending_o   = pending_q;
    assign hex_digit_o = hex_q;
    assign digit_idx_o = idx_q;
    assign digit_en_o  = en_q;

endmodule : seven_seg_scan_mux

`default_nettype wire
